// File: rtl/pipe_mem_responder.sv
// rtl/pipe_mem_responder.sv - word-organised memory responder with configurable wait states
module pipe_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        error
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BASE    = ADDR_BASE;
  localparam logic [30:0] DEPTH_L = 31'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] mem [DEPTH_WORDS];

  logic        req;
  logic        accept;
  logic [29:0] word_idx;
  logic        in_range;
  logic [AW-1:0] ram_idx;

  // Address decode: low two bits only matter for the below-base test.
  always_comb begin
    req      = read | write;
    word_idx = address[31:2] - BASE[31:2];
    in_range = (address >= BASE) && ({1'b0, word_idx} < DEPTH_L);
    ram_idx  = word_idx[AW-1:0];
  end

  // Stall while a fresh request starts its wait or the wait count is still running.
  always_comb begin
    waitrequest = 1'b0;
    if (state == IDLE && req && (WAIT_CYCLES > 0))
      waitrequest = 1'b1;
    else if (state == BUSY && count != 4'd0)
      waitrequest = 1'b1;
    accept = req && !waitrequest;
  end

  // Wait-state FSM plus registered read data and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      count         <= 4'd0;
      readdata      <= 32'd0;
      readdatavalid <= 1'b0;
      error         <= 1'b0;
    end else begin
      readdatavalid <= 1'b0;
      error         <= 1'b0;
      case (state)
        IDLE: begin
          if (req && (WAIT_CYCLES > 0)) begin
            state <= BUSY;
            count <= WAIT_LD;
          end
        end
        BUSY: begin
          // A dropped request abandons the wait without any access.
          if (!req)
            state <= IDLE;
          else if (count != 4'd0)
            count <= count - 4'd1;
          else
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        if (read && write) begin
          error <= 1'b1;
        end else if (!in_range) begin
          error <= 1'b1;
          if (read) begin
            readdatavalid <= 1'b1;
            readdata      <= 32'd0;
          end
        end else if (read) begin
          readdatavalid <= 1'b1;
          readdata      <= mem[ram_idx];
        end
      end
    end
  end

  // Byte-lane store; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset_n && accept && write && !read && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i])
          mem[ram_idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_responder.sv
// tb/tb_pipe_mem_responder.sv - self-checking bench for pipe_mem_responder
module tb_pipe_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [3:0]  be    [3];
  logic [31:0] wdata [3];
  logic        wreq  [3];
  logic [31:0] rdata [3];
  logic        rdv   [3];
  logic        err   [3];

  int total = 0;
  int bad   = 0;

  int          waits  [3] = '{0, 3, 4};
  logic [31:0] bases  [3] = '{32'h0, 32'h400, 32'h0};
  int          depths [3] = '{1024, 256, 1024};

  logic [31:0] mref [int];

  always #5 clk = ~clk;

  pipe_mem_responder #(.ADDR_BASE(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset_n(rst_n[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .byteenable(be[0]), .writedata(wdata[0]), .waitrequest(wreq[0]), .readdata(rdata[0]),
    .readdatavalid(rdv[0]), .error(err[0]));

  pipe_mem_responder #(.ADDR_BASE(32'h400), .DEPTH_WORDS(256), .WAIT_CYCLES(3), .INIT_FILE("")) dut1 (
    .clk(clk), .reset_n(rst_n[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .byteenable(be[1]), .writedata(wdata[1]), .waitrequest(wreq[1]), .readdata(rdata[1]),
    .readdatavalid(rdv[1]), .error(err[1]));

  pipe_mem_responder #(.ADDR_BASE(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(4), .INIT_FILE("")) dut2 (
    .clk(clk), .reset_n(rst_n[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
    .byteenable(be[2]), .writedata(wdata[2]), .waitrequest(wreq[2]), .readdata(rdata[2]),
    .readdatavalid(rdv[2]), .error(err[2]));

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic        e_rdv;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Present a request and hold it until accepted; return stall count and next-cycle outputs.
  task automatic do_req(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic o_rdv, output logic o_err, output logic [31:0] o_rd,
                        output int stalls);
    rd[k] = r; wr[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    stalls = 0;
    #1;
    while (wreq[k] && stalls < 40) begin
      stalls++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    o_rdv = rdv[k]; o_err = err[k]; o_rd = rdata[k];
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  task automatic run_op(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        input logic e_rdv, input logic e_err, input logic [31:0] e_rd,
                        input bit chk_rd, input string tag);
    logic g_rdv, g_err;
    logic [31:0] g_rd;
    int st;
    do_req(k, r, w, a, b, d, g_rdv, g_err, g_rd, st);
    chk({tag, "_stall"}, st, waits[k]);
    chk({tag, "_rdv"}, g_rdv, e_rdv);
    chk({tag, "_err"}, g_err, e_err);
    if (chk_rd) chk({tag, "_rdata"}, g_rd, e_rd);
  endtask

  // Reference: byte-addressed decode against base/depth, lane-wise merge into a word map.
  task automatic model(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output logic e_rdv, output logic e_err, output logic [31:0] e_rd);
    longint idx;
    bit inr;
    int key;
    logic [31:0] cur;
    inr = 0; idx = 0;
    if ({32'h0, a} >= {32'h0, bases[k]}) begin
      idx = ({32'h0, a} - {32'h0, bases[k]}) / 4;
      inr = (idx < depths[k]);
    end
    key = k * 4096 + int'(idx % 4096);
    e_rdv = 0; e_err = 0; e_rd = 0;
    if (r && w) begin
      e_err = 1;
    end else if (!inr) begin
      e_err = 1;
      e_rdv = r;
    end else if (w) begin
      cur = mref.exists(key) ? mref[key] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
      mref[key] = cur;
    end else begin
      e_rdv = 1;
      e_rd = mref[key];
    end
  endtask

  task automatic rand_op(input int k, input bit init, input int widx);
    logic r, w, e_rdv, e_err;
    logic [31:0] a, d, e_rd;
    logic [3:0] b;
    int sel, op;
    if (init) begin
      r = 0; w = 1; b = 4'hF; sel = widx;
    end else begin
      op = $urandom_range(0, 8);
      r = (op >= 4); w = (op < 4) || (op == 8);
      b = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 9);
    end
    d = $urandom;
    if (sel < 8) a = bases[k] + 32'(sel * 4) + 32'($urandom_range(0, 3));
    else if (sel == 8) a = bases[k] + 32'(depths[k] * 4) + 32'($urandom_range(0, 3));
    else a = (bases[k] == 32'h0) ? 32'hFFFF_FFF0 : bases[k] - 32'd4;
    model(k, r, w, a, b, d, e_rdv, e_err, e_rd);
    run_op(k, r, w, a, b, d, e_rdv, e_err, e_rd, e_rdv, $sformatf("rnd%0d", k));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
      addr[k] = 32'h0; be[k] = 4'h0; wdata[k] = 32'h0;
    end
    rd[0] = 1'b1;
    addr[0] = 32'h10;

    //           r  w  addr          be     wdata          rdv err rdata
    tbl[0]  = '{0, 1, 32'h10,   4'hF, 32'hDEADBEEF, 0, 0, 32'h0};
    tbl[1]  = '{1, 0, 32'h10,   4'hF, 32'h0,        1, 0, 32'hDEADBEEF};
    tbl[2]  = '{0, 1, 32'h10,   4'h2, 32'h0000AA00, 0, 0, 32'hDEADBEEF};
    tbl[3]  = '{1, 0, 32'h13,   4'h0, 32'h0,        1, 0, 32'hDEADAAEF};
    tbl[4]  = '{0, 1, 32'h10,   4'h0, 32'hFFFFFFFF, 0, 0, 32'hDEADAAEF};
    tbl[5]  = '{1, 0, 32'h10,   4'hF, 32'h0,        1, 0, 32'hDEADAAEF};
    tbl[6]  = '{1, 0, 32'h1000, 4'hF, 32'h0,        1, 1, 32'h0};
    tbl[7]  = '{0, 1, 32'h20,   4'hF, 32'h12345678, 0, 0, 32'h0};
    tbl[8]  = '{1, 1, 32'h20,   4'hF, 32'hFFFFFFFF, 0, 1, 32'h0};
    tbl[9]  = '{1, 0, 32'h20,   4'hF, 32'h0,        1, 0, 32'h12345678};
    tbl[10] = '{0, 1, 32'hFFC,  4'hF, 32'hCAFEF00D, 0, 0, 32'h12345678};
    tbl[11] = '{1, 0, 32'hFFC,  4'hF, 32'h0,        1, 0, 32'hCAFEF00D};
    tbl[12] = '{0, 1, 32'h0,    4'hF, 32'h00000000, 0, 0, 32'hCAFEF00D};
    tbl[13] = '{0, 1, 32'h1000, 4'hF, 32'h11111111, 0, 1, 32'hCAFEF00D};
    tbl[14] = '{1, 0, 32'h0,    4'hF, 32'h0,        1, 0, 32'h00000000};

    // Reset held two cycles with a read pending on the zero-wait instance.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_wreq", wreq[0], 1'b0);
      chk("rst_rdv", rdv[0], 1'b0);
    end
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    rd[0] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
      chk($sformatf("rst_err%0d", k), err[k], 1'b0);
      chk($sformatf("rst_rdv%0d", k), rdv[k], 1'b0);
    end

    // Zero-wait instance: back-to-back table vectors.
    @(negedge clk);
    for (int i = 0; i < 15; i++)
      run_op(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d,
             tbl[i].e_rdv, tbl[i].e_err, tbl[i].e_rd, 1'b1, $sformatf("tbl%0d", i));

    // Three wait states: read held from cycle 0, second read held from cycle 4.
    @(negedge clk);
    rd[1] = 1'b1;
    addr[1] = 32'h400;
    for (int c = 0; c <= 8; c++) begin
      #1;
      if (c < 8) chk($sformatf("w3_wreq_c%0d", c), wreq[1], (c % 4) != 3);
      chk($sformatf("w3_rdv_c%0d", c), rdv[1], (c == 4) || (c == 8));
      if (c < 8) @(negedge clk);
    end
    rd[1] = 1'b0;

    // Four wait states: reset during the second wait cycle drops the request.
    @(negedge clk);
    rd[2] = 1'b1;
    addr[2] = 32'h40;
    #1;
    chk("w4_wreq_c0", wreq[2], 1'b1);
    @(negedge clk);
    rst_n[2] = 1'b0;
    rd[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("w4_post_rst_rdv", rdv[2], 1'b0);
      chk("w4_post_rst_err", err[2], 1'b0);
    end
    run_op(2, 1'b0, 1'b1, 32'h40, 4'hF, 32'hA5A55A5A, 1'b0, 1'b0, 32'h0, 1'b0, "w4_wr");
    run_op(2, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 1'b0, 32'hA5A55A5A, 1'b1, "w4_rd");

    // Randomized traffic against the reference model on both waited and zero-wait instances.
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) rand_op(k, 1'b1, i);
      for (int n = 0; n < 150; n++) rand_op(k, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
